// File: rtl/image_proc_pkg.sv
// Shared types and sizing helpers for the image processing datapath.
package image_proc_pkg;

   localparam int unsigned IMG_W_DEF = 64;
   localparam int unsigned IMG_H_DEF = 64;
   localparam int unsigned CNT_W     = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CAPTURE = 2'b01,
      PROCESS = 2'b10,
      READOUT = 2'b11
   } state_e;

   function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
      return $clog2(w * h);
   endfunction

endpackage

// File: rtl/frame_sequencer_raster_counter.sv
// Row/column raster counter with a linear address, clear, enable and end-of-frame flag.
module raster_counter
   import image_proc_pkg::*;
#(
   parameter int unsigned W      = IMG_W_DEF,
   parameter int unsigned H      = IMG_H_DEF,
   parameter int unsigned ADDR_W = addr_width(IMG_W_DEF, IMG_H_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   output logic [CNT_W-1:0]  row,
   output logic [CNT_W-1:0]  col,
   output logic [ADDR_W-1:0] addr,
   output logic              eof_c
);

   logic [CNT_W-1:0]  row_q, row_d;
   logic [CNT_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   assign eof_c = (row_q == CNT_W'(H - 1)) && (col_q == CNT_W'(W - 1));

   // Clear wins over enable; the whole raster wraps to zero after the last pixel.
   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      if (clr) begin
         row_d  = '0;
         col_d  = '0;
         addr_d = '0;
      end else if (en) begin
         if (col_q == CNT_W'(W - 1)) begin
            col_d = '0;
            row_d = (row_q == CNT_W'(H - 1)) ? '0 : row_q + CNT_W'(1);
         end else begin
            col_d = col_q + CNT_W'(1);
         end
         addr_d = eof_c ? '0 : addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q  <= '0;
         col_q  <= '0;
         addr_q <= '0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         addr_q <= addr_d;
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign addr = addr_q;

endmodule

// File: rtl/frame_sequencer.sv
// Frame controller: CAPTURE -> PROCESS -> READOUT with address generation and status.
// Optional PROCESS watchdog enabled by defining FRAME_SEQ_WDOG_EN.
module frame_sequencer
   import image_proc_pkg::*;
#(
   parameter int unsigned IMG_W       = IMG_W_DEF,
   parameter int unsigned IMG_H       = IMG_H_DEF,
   parameter int unsigned ADDR_W      = addr_width(IMG_W_DEF, IMG_H_DEF),
   parameter int unsigned WDOG_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              cap_we,
   output logic [ADDR_W-1:0] cap_addr,
   output logic [5:0]        row,
   output logic [5:0]        col,
   output logic              proc_start,
   input  logic              proc_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic [1:0]        state,
   output logic              busy,
   output logic [7:0]        frame_cnt,
   output logic              err
);

   localparam int unsigned LAST_ADDR = IMG_W * IMG_H - 1;

   state_e     state_q, state_d;
   logic       err_q, err_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       proc_start_q, proc_start_d;

   logic cap_clr_c, cap_eof_c;
   logic rd_en_c, rd_clr_c;
   logic wdog_expired_c;
   logic [CNT_W-1:0] rd_row_unused, rd_col_unused;
   logic             rd_eof_unused;

   assign in_ready  = (state_q == CAPTURE);
   assign cap_we    = in_valid & in_ready;
   assign out_valid = (state_q == READOUT);
   assign out_last  = (out_addr == ADDR_W'(LAST_ADDR));
   assign busy      = (state_q != IDLE);
   assign cap_clr_c = (state_q == IDLE) & frame_start;
   assign rd_en_c   = out_valid & out_ready;
   assign rd_clr_c  = (state_q == PROCESS) & proc_done;

   raster_counter #(.W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)) u_cap_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cap_clr_c),
      .en    (cap_we),
      .row   (row),
      .col   (col),
      .addr  (cap_addr),
      .eof_c (cap_eof_c)
   );

   raster_counter #(.W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)) u_rd_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (rd_clr_c),
      .en    (rd_en_c),
      .row   (rd_row_unused),
      .col   (rd_col_unused),
      .addr  (out_addr),
      .eof_c (rd_eof_unused)
   );

`ifdef FRAME_SEQ_WDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_q, wdog_d;

   // Held at zero through CAPTURE so every PROCESS entry starts a fresh count.
   always_comb begin
      wdog_d = wdog_q;
      if (state_q == CAPTURE) begin
         wdog_d = '0;
      end else if (state_q == PROCESS) begin
         wdog_d = wdog_q + WDOG_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end

   assign wdog_expired_c = (state_q == PROCESS) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
`else
   logic unused_wdog;
   assign unused_wdog    = ^WDOG_CYCLES;
   assign wdog_expired_c = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      frame_cnt_d  = frame_cnt_q;
      proc_start_d = 1'b0;

      if (frame_start && (state_q != IDLE)) err_d = 1'b1;
      if (proc_done && (state_q != PROCESS)) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (frame_start) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (cap_we && cap_eof_c) begin
               state_d      = PROCESS;
               proc_start_d = 1'b1;
            end
         end
         PROCESS: begin
            if (proc_done) begin
               state_d = READOUT;
            end else if (wdog_expired_c) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         READOUT: begin
            if (out_ready && out_last) begin
               state_d     = IDLE;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         err_q        <= 1'b0;
         frame_cnt_q  <= 8'd0;
         proc_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         frame_cnt_q  <= frame_cnt_d;
         proc_start_q <= proc_start_d;
      end
   end

   assign state      = state_q;
   assign err        = err_q;
   assign frame_cnt  = frame_cnt_q;
   assign proc_start = proc_start_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: queued expected capture/start/readout events plus status checks.
module tb_frame_sequencer;

`ifdef FRAME_SEQ_WDOG_EN
   localparam int unsigned TB_WDOG = 50;
`else
   localparam int unsigned TB_WDOG = 100000;
`endif

   localparam int unsigned NPIX = 4096;

   logic        clk = 1'b0;
   logic        rst, frame_start, in_valid, proc_done, out_ready;
   logic        in_ready, cap_we, proc_start, out_valid, out_last, busy, err;
   logic [11:0] cap_addr, out_addr;
   logic [5:0]  row, col;
   logic [1:0]  state;
   logic [7:0]  frame_cnt;

   typedef struct packed {
      logic [1:0]  kind;
      logic [11:0] addr;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   n_run  = 0;
   int   n_fail = 0;
   bit   done   = 1'b0;

   always #5 clk = ~clk;

   frame_sequencer #(.WDOG_CYCLES(TB_WDOG)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cap_we      (cap_we),
      .cap_addr    (cap_addr),
      .row         (row),
      .col         (col),
      .proc_start  (proc_start),
      .proc_done   (proc_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_last    (out_last),
      .state       (state),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .err         (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input logic [1:0] kind, input int addr, input logic last);
      exp_t e;
      e.kind = kind;
      e.addr = 12'(addr);
      e.last = last;
      exp_q.push_back(e);
   endtask

   // Observed event: kind 0 = capture write, 1 = proc_start, 2 = readout handshake.
   task automatic mon_event(input logic [1:0] kind, input logic [11:0] addr, input logic last);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_run++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d addr %0d, expected none", kind, addr);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", 32'(kind), 32'(e.kind));
         chk("ev_addr", 32'(addr), 32'(e.addr));
         chk("ev_last", 32'(last), 32'(e.last));
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_row"}, 32'(row), 0);
      chk({tag, "_col"}, 32'(col), 0);
      chk({tag, "_cap_addr"}, 32'(cap_addr), 0);
      chk({tag, "_out_addr"}, 32'(out_addr), 0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
      chk({tag, "_cap_we"}, 32'(cap_we), 0);
      chk({tag, "_proc_start"}, 32'(proc_start), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic do_capture(input bit stall, input bit errs);
      int acc = 0;
      int cyc = 0;
      for (int i = 0; i < NPIX; i++) push_ev(2'd0, i, 1'b0);
      push_ev(2'd1, 0, 1'b0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("cap_entry_state", 32'(state), 1);
      chk("cap_entry_addr", 32'(cap_addr), 0);
      while (acc < NPIX) begin
         in_valid = stall ? ((cyc % 2) == 0) : 1'b1;
         if (errs && cyc == 20) frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         if (in_valid) acc++;
         cyc++;
         if (errs && cyc == 21) chk("err_after_fs_in_capture", 32'(err), 1);
         if (in_valid && acc == 65) begin
            chk("row_after_65", 32'(row), 1);
            chk("col_after_65", 32'(col), 1);
         end
      end
      in_valid = 1'b0;
      chk("capture_cycles", 32'(cyc), stall ? 8191 : 4096);
      chk("process_state", 32'(state), 2);
   endtask

   task automatic run_frame(input bit stall, input bit bp, input bit errs,
                            input logic [7:0] exp_cnt, input logic exp_err);
      int  hs = 0;
      bit  bp_done = 1'b0;
      do_capture(stall, errs);
      for (int i = 0; i < NPIX; i++) push_ev(2'd2, i, (i == NPIX - 1));
      repeat (10) tick();
      chk("still_process", 32'(state), 2);
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      chk("readout_state", 32'(state), 3);
      chk("readout_addr0", 32'(out_addr), 0);
      while (hs < NPIX) begin
         if (bp && hs == 100 && !bp_done) begin
            out_ready = 1'b0;
            repeat (5) begin
               chk("bp_hold_addr", 32'(out_addr), 100);
               chk("bp_valid", 32'(out_valid), 1);
               tick();
            end
            bp_done = 1'b1;
            chk("bp_after_addr", 32'(out_addr), 100);
         end
         out_ready = 1'b1;
         if (errs && hs == 10) proc_done = 1'b1;
         tick();
         proc_done = 1'b0;
         hs++;
         if (errs && hs == 11) chk("err_after_pd_in_readout", 32'(err), 1);
      end
      chk("end_state", 32'(state), 0);
      chk("end_busy", 32'(busy), 0);
      chk("end_out_valid", 32'(out_valid), 0);
      chk("end_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      chk("end_err", 32'(err), 32'(exp_err));
   endtask

   initial begin
      rst = 1'b1;
      frame_start = 1'b0;
      in_valid = 1'b0;
      proc_done = 1'b0;
      out_ready = 1'b1;
      fork
         begin
            #3;
            chk_reset("por");
            tick();
            rst = 1'b0;
            tick();

            run_frame(1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
            tick();
            run_frame(1'b1, 1'b0, 1'b0, 8'd2, 1'b0);
            tick();
            run_frame(1'b0, 1'b1, 1'b1, 8'd3, 1'b1);
            tick();

            do_capture(1'b0, 1'b0);
            repeat (3) tick();
            #2;
            rst = 1'b1;
            #1;
            chk_reset("mid_proc_rst");
            tick();
            rst = 1'b0;
            tick();

            run_frame(1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
            tick();

`ifdef FRAME_SEQ_WDOG_EN
            do_capture(1'b0, 1'b0);
            repeat (TB_WDOG - 1) tick();
            chk("wdog_before_expiry", 32'(state), 2);
            tick();
            chk("wdog_state", 32'(state), 0);
            chk("wdog_err", 32'(err), 1);
            chk("wdog_frame_cnt", 32'(frame_cnt), 1);
            repeat (5) tick();
`endif
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (!rst) begin
                  if (cap_we) mon_event(2'd0, cap_addr, 1'b0);
                  if (proc_start) mon_event(2'd1, 12'd0, 1'b0);
                  if (out_valid && out_ready) mon_event(2'd2, out_addr, out_last);
               end
            end
         end
      join
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
